uart_tx_param: RTL

Parametrised single-clock UART transmitter, successor to the fixed 8-bit `uart_tx`. The external baud×8 clock is gone: an internal prescaler, configured at run time, derives bit timing from `i_clk`. Data width and oversampling are compile-time parameters; parity and stop-bit count are selectable per frame. It sits between a CPU/bus register interface and the TX pin, with the same write/busy handshake as `uart_tx`.

---
 rtl/uart_tx_param.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with run-time prescaler
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic [1:0]           i_parity,
  input  logic                 i_stop2,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_bsy,
  output logic                 o_tx,
  output logic                 o_bit_strobe,
  output logic                 o_done
);

  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] pre_q, pre_d;
  logic [SUB_W-1:0]     sub_q, sub_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 tx_q, tx_d;
  logic                 bsy_q, bsy_d;
  logic                 stb_q, stb_d;
  logic                 done_q, done_d;
  logic                 pre_wrap;
  logic                 bit_end;

  // Prescaler wraps at the latched divisor; a bit ends when both counters wrap together.
  assign pre_wrap = (pre_q == div_q);
  assign bit_end  = pre_wrap && (sub_q == SUB_LAST);

  // Next-state and registered-output decode; every bit start raises the strobe.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    sub_d      = sub_q;
    bit_d      = bit_q;
    data_d     = data_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    bsy_d      = bsy_q;
    stb_d      = 1'b0;
    done_d     = 1'b0;

    if (state_q != S_IDLE) begin
      if (bit_end) begin
        pre_d = '0;
        sub_d = '0;
      end else if (pre_wrap) begin
        pre_d = '0;
        sub_d = sub_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (i_wr && !bsy_q) begin
          state_d    = S_START;
          pre_d      = '0;
          sub_d      = '0;
          bit_d      = '0;
          stop_idx_d = 1'b0;
          data_d     = i_data;
          div_d      = i_div;
          par_en_d   = (i_parity == 2'b01) || (i_parity == 2'b10);
          par_bit_d  = (^i_data) ^ (i_parity == 2'b10);
          stop2_d    = i_stop2;
          tx_d       = 1'b0;
          bsy_d      = 1'b1;
          stb_d      = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = data_q[0];
          data_d  = data_q >> 1;
          stb_d   = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          stb_d = 1'b1;
          if (bit_q == BIT_LAST) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = S_STOP;
              stop_idx_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_d  = bit_q + 1'b1;
            tx_d   = data_q[0];
            data_d = data_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
          stb_d      = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            stb_d      = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            bsy_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        bsy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any accept in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      sub_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      bsy_q      <= 1'b0;
      stb_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      sub_q      <= sub_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      bsy_q      <= bsy_d;
      stb_q      <= stb_d;
      done_q     <= done_d;
    end
  end

  assign o_tx         = tx_q;
  assign o_bsy        = bsy_q;
  assign o_bit_strobe = stb_q;
  assign o_done       = done_q;

endmodule
